// File: rtl/calc_pkg.sv
// Shared types for the calculator core: number format and ALU arbiter state.
package calc_pkg;

    // Magnitude width of a calculator number (signed, hundredths).
    localparam int unsigned NumW = 16;

    // Number of requesters sharing the alu_add instance.
    localparam int unsigned NumAluReq = 2;

    // Calculator number: sticky error flag plus a fixed-point value.
    typedef struct packed {
        logic            error;
        logic [NumW-1:0] value;
    } num_t;

    // Shared alu_add arbiter states.
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_WAIT    = 2'd2,
        S_RESPOND = 2'd3
    } alu_arb_state_t;

endpackage

// File: rtl/calc_rr_pick.sv
// Round-robin pick: first set valid bit at or after base, wrapping modulo N.
module calc_rr_pick #(
    parameter int unsigned N = 2,
    localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    valid,
    input  logic [IdxW-1:0] base,
    output logic [IdxW-1:0] winner,
    output logic            any_valid
);

    logic [IdxW-1:0] idx;

    // Scan from base upward with wrap; the first hit wins.
    always_comb begin
        winner    = '0;
        any_valid = 1'b0;
        idx       = '0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = IdxW'((32'(base) + i) % N);
            if (!any_valid && valid[idx]) begin
                winner    = idx;
                any_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_add_arbiter.sv
// Shares one alu_add between NumReq requesters, one operation in flight.
module alu_add_arbiter
    import calc_pkg::*;
#(
    parameter int unsigned NumReq = NumAluReq
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  num_t              req_left_i  [NumReq],
    input  num_t              req_right_i [NumReq],
    input  logic [NumReq-1:0] req_valid_i,
    output logic [NumReq-1:0] req_ready_o,
    output num_t              rsp_result_o,
    output logic [NumReq-1:0] rsp_valid_o,
    input  logic [NumReq-1:0] rsp_ready_i,
    output num_t              alu_left_o,
    output num_t              alu_right_o,
    output logic              alu_in_valid_o,
    input  logic              alu_in_ready_i,
    input  num_t              alu_result_i,
    input  logic              alu_out_valid_i,
    output logic              alu_out_ready_o
);

    localparam int unsigned IdxW = $clog2(NumReq);

    alu_arb_state_t  state_q, state_d;
    logic [IdxW-1:0] rr_q, rr_d;
    logic [IdxW-1:0] grant_q, grant_d;
    num_t            left_q, left_d;
    num_t            right_q, right_d;
    num_t            result_q, result_d;
    logic [IdxW-1:0] winner;
    logic            any_valid;

    calc_rr_pick #(
        .N (NumReq)
    ) u_pick (
        .valid     (req_valid_i),
        .base      (rr_q),
        .winner    (winner),
        .any_valid (any_valid)
    );

    // State and datapath registers; reset drops any transaction in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            rr_q     <= '0;
            grant_q  <= '0;
            left_q   <= '0;
            right_q  <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            grant_q  <= grant_d;
            left_q   <= left_d;
            right_q  <= right_d;
            result_q <= result_d;
        end
    end

    // Next state and outputs; ready in idle is gated by reset so outputs are 0 in reset.
    always_comb begin
        state_d         = state_q;
        rr_d            = rr_q;
        grant_d         = grant_q;
        left_d          = left_q;
        right_d         = right_q;
        result_d        = result_q;
        req_ready_o     = '0;
        rsp_valid_o     = '0;
        rsp_result_o    = '0;
        alu_left_o      = '0;
        alu_right_o     = '0;
        alu_in_valid_o  = 1'b0;
        alu_out_ready_o = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (rst_ni && any_valid) begin
                    req_ready_o[winner] = 1'b1;
                    left_d              = req_left_i[winner];
                    right_d             = req_right_i[winner];
                    grant_d             = winner;
                    state_d             = S_ISSUE;
                end
            end
            S_ISSUE: begin
                alu_in_valid_o = 1'b1;
                alu_left_o     = left_q;
                alu_right_o    = right_q;
                if (alu_in_ready_i) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                alu_out_ready_o = 1'b1;
                if (alu_out_valid_i) begin
                    result_d = alu_result_i;
                    state_d  = S_RESPOND;
                end
            end
            S_RESPOND: begin
                rsp_valid_o[grant_q] = 1'b1;
                rsp_result_o         = result_q;
                if (rsp_ready_i[grant_q]) begin
                    rr_d    = (grant_q == IdxW'(NumReq - 1)) ? '0 : IdxW'(32'(grant_q) + 32'd1);
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule
